pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Producer side of the PC stall interface. Generates the three freeze inputs the PC register consumes: hazard, BranchBubble and cp0Bubble.
- Sits beside the ID stage of the 5-stage MIPS pipeline.
- Detects load-use hazards combinationally.
- Sequences fixed-length bubble windows for branches/jumps and CP0 ops (mtc0, eret, syscall) with a small FSM.
- Drives the matching IF/ID and ID/EX NOP-insert controls.

Parameters:
- BR_BUBBLES, 2, PC freeze cycles after a branch/jump leaves ID (1..7).
- CP0_BUBBLES, 3, PC freeze cycles after a CP0 op leaves ID (1..7).
- REG_W, 5, register specifier width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- id_rs  in  REG_W  rs of the instruction in ID.
- id_rt  in  REG_W  rt of the instruction in ID.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  REG_W  destination register of the load in EX.
- id_branch  in  1  branch/jump decoded in ID.
- id_cp0_op  in  1  mtc0/eret/syscall decoded in ID.
- hazard  out  1  load-use stall; PC and IF/ID hold.
- BranchBubble  out  1  PC freeze during the branch window.
- cp0Bubble  out  1  PC freeze during the CP0 window.
- ifid_nop  out  1  IF/ID loads a NOP this edge.
- idex_nop  out  1  ID/EX loads a NOP this edge.

Behaviour:
- Reset is decided as: reset Reset, synchronous, active-high; clock Clk.
- Reset state:
  - FSM=IDLE, cnt=0.
  - All five outputs are forced 0 combinationally while Reset=1, so the PC can load its reset vector (word 0x0000000D) on the same edge.
- FSM states: IDLE, BR, CP0. cnt is a 3-bit down-counter.
- IDLE transitions (evaluated only when hazard=0):
  - id_cp0_op=1 -> CP0, cnt=CP0_BUBBLES-1.
  - else id_branch=1 -> BR, cnt=BR_BUBBLES-1.
  - else stay in IDLE.
- BR / CP0: if cnt==0 -> IDLE; else cnt-1.
- BranchBubble = (state==BR) & !Reset. cp0Bubble = (state==CP0) & !Reset. Both are decoded from registered state, so the first bubble cycle is the cycle after the op is sampled in ID.
- Bubble window length is exactly BR_BUBBLES or CP0_BUBBLES cycles, then IDLE.
- hazard (combinational) = !Reset & state==IDLE & ex_mem_read & ex_rt!=0 & ((id_use_rs & id_rs==ex_rt) | (id_use_rt & id_rt==ex_rt)).
  - Asserted for exactly 1 cycle per load-use pair; the load advances, so the compare clears next cycle.
- ifid_nop = BranchBubble | cp0Bubble. idex_nop = hazard | BranchBubble | cp0Bubble.
- Boundary rules:
  - id_cp0_op and id_branch both set: CP0 wins; the branch is not separately bubbled.
  - hazard=1 with id_branch or id_cp0_op: transition is suppressed. The instruction stays in ID and is re-evaluated next cycle, so the window starts one cycle later.
  - id_branch/id_cp0_op arriving while in BR or CP0: ignored, since ID holds a NOP.
  - ex_rt==0: never a hazard.
  - Reset mid-window: outputs drop to 0 immediately; FSM=IDLE at that edge; no residual bubble after Reset deasserts.
  - At most one of hazard/BranchBubble/cp0Bubble is 1 in any cycle.

Optional Feature:
- Macro STALL_CTRL_PERF_EN.
- Defined: adds 32-bit saturating counters perf_haz, perf_br, perf_cp0 (extra outputs).
  - Each increments on cycles where its stall output is 1.
  - Cleared by Reset; holds at 0xFFFFFFFF.
- Undefined: no counters and no extra ports; functional behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state encoding constants (ST_IDLE=2'd0, ST_BR=2'd1, ST_CP0=2'd2);
  - the ZERO_REG constant;
  - the default bubble counts.
- Sub-module load_use_detect holds the combinational hazard compare. The FSM and counter stay in pipe_stall_ctrl.

Test Plan:
- Reset held 2 cycles while forcing an in-flight CP0 window -> all outputs 0 during Reset; FSM=IDLE after; PC loads 0x0000000D.
- ex_mem_read=1, ex_rt=8, id_rs=8, id_use_rs=1 -> hazard=1 and idex_nop=1 for 1 cycle; same stimulus with ex_rt=0 -> hazard=0.
- id_branch pulse in IDLE, BR_BUBBLES=2 -> BranchBubble=1 and ifid_nop=1 on cycles +1 and +2, then 0.
- id_branch=1 and id_cp0_op=1 together, CP0_BUBBLES=3 -> cp0Bubble high 3 cycles; BranchBubble never asserts.
- Load-use hazard coincident with id_branch -> hazard cycle first; BranchBubble starts one cycle later and lasts 2 cycles.
- STALL_CTRL_PERF_EN defined: run the branch scenario 3 times -> perf_br=6, perf_haz=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the PC stall controller: FSM state encoding,
// the hard-wired zero register and the default bubble window lengths.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BR   = 2'd1,
    ST_CP0  = 2'd2
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam int DEF_BR_BUBBLES  = 2;
  localparam int DEF_CP0_BUBBLES = 3;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the source
// registers of the instruction in ID. A load into $zero never conflicts.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             mem_read,
  input  logic [REG_W-1:0] load_rt,
  output logic             match
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = use_rs && (rs == load_rt);
  assign rt_hit = use_rt && (rt == load_rt);
  assign match  = mem_read && (load_rt != REG_W'(ZERO_REG)) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// PC stall producer beside ID: load-use hazard plus fixed-length branch and
// CP0 bubble windows. Define STALL_CTRL_PERF_EN to add saturating stall counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BR_BUBBLES  = DEF_BR_BUBBLES,
  parameter int CP0_BUBBLES = DEF_CP0_BUBBLES,
  parameter int REG_W       = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_branch,
  input  logic             id_cp0_op,
  output logic             hazard,
  output logic             BranchBubble,
  output logic             cp0Bubble,
  output logic             ifid_nop,
  output logic             idex_nop
`ifdef STALL_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_haz,
  output logic [31:0]      perf_br,
  output logic [31:0]      perf_cp0
`endif
);

  localparam logic [2:0] BR_LOAD  = 3'(BR_BUBBLES - 1);
  localparam logic [2:0] CP0_LOAD = 3'(CP0_BUBBLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       match;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .rs       (id_rs),
    .rt       (id_rt),
    .use_rs   (id_use_rs),
    .use_rt   (id_use_rt),
    .mem_read (ex_mem_read),
    .load_rt  (ex_rt),
    .match    (match)
  );

  // Outputs are masked by Reset so the PC can take its reset vector this edge.
  assign hazard       = !Reset && (state == ST_IDLE) && match;
  assign BranchBubble = !Reset && (state == ST_BR);
  assign cp0Bubble    = !Reset && (state == ST_CP0);
  assign ifid_nop     = BranchBubble || cp0Bubble;
  assign idex_nop     = hazard || BranchBubble || cp0Bubble;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A hazard holds the op in ID; it is re-sampled next cycle.
          if (!hazard) begin
            if (id_cp0_op) begin
              state <= ST_CP0;
              cnt   <= CP0_LOAD;
            end else if (id_branch) begin
              state <= ST_BR;
              cnt   <= BR_LOAD;
            end
          end
        end
        default: begin
          if (cnt == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
      endcase
    end
  end

`ifdef STALL_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      perf_haz <= 32'd0;
      perf_br  <= 32'd0;
      perf_cp0 <= 32'd0;
    end else begin
      perf_haz <= sat_inc(perf_haz, hazard);
      perf_br  <= sat_inc(perf_br, BranchBubble);
      perf_cp0 <= sat_inc(perf_cp0, cp0Bubble);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed boundary scenarios then
// randomized traffic against a remaining-cycles window model.
module tb_pipe_stall_ctrl;
  localparam int BR_B  = 2;
  localparam int CP0_B = 3;
  localparam int REG_W = 5;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_use_rs, id_use_rt, ex_mem_read, id_branch, id_cp0_op;
  logic             hazard, BranchBubble, cp0Bubble, ifid_nop, idex_nop;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0]      perf_haz, perf_br, perf_cp0;
`endif

  always #5 Clk = ~Clk;

  pipe_stall_ctrl #(.BR_BUBBLES(BR_B), .CP0_BUBBLES(CP0_B), .REG_W(REG_W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .id_branch    (id_branch),
    .id_cp0_op    (id_cp0_op),
    .hazard       (hazard),
    .BranchBubble (BranchBubble),
    .cp0Bubble    (cp0Bubble),
    .ifid_nop     (ifid_nop),
    .idex_nop     (idex_nop)
`ifdef STALL_CTRL_PERF_EN
    ,
    .perf_haz     (perf_haz),
    .perf_br      (perf_br),
    .perf_cp0     (perf_cp0)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles of bubble still owed and which kind.
  int win_left = 0;
  bit win_cp0  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_hazard();
    if (Reset || win_left != 0 || !ex_mem_read || ex_rt == 0) return 1'b0;
    return (id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt);
  endfunction

  function automatic logic [4:0] got_vec();
    return {hazard, BranchBubble, cp0Bubble, ifid_nop, idex_nop};
  endfunction

  // Inputs are applied at a negedge; check mid-cycle, then advance the model.
  task automatic step(input string tag);
    bit hz, bb, cb;
    #1;
    hz = ref_hazard();
    bb = !Reset && win_left > 0 && !win_cp0;
    cb = !Reset && win_left > 0 && win_cp0;
    chk(tag, 32'(got_vec()), 32'({hz, bb, cb, bb | cb, hz | bb | cb}));
    chk({tag, "_excl"}, 32'($countones({hazard, BranchBubble, cp0Bubble}) <= 1), 32'd1);
    @(posedge Clk);
    if (Reset) win_left = 0;
    else if (win_left > 0) win_left--;
    else if (!hz) begin
      if (id_cp0_op) begin win_left = CP0_B; win_cp0 = 1'b1; end
      else if (id_branch) begin win_left = BR_B; win_cp0 = 1'b0; end
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
    id_branch = 1'b0; id_cp0_op = 1'b0;
  endtask

  int br_cycles;
  int cp0_cycles;

  initial begin
    idle_inputs();
    Reset = 1'b1;
    @(negedge Clk);
    step("rst_a");
    step("rst_b");
    Reset = 1'b0;
    step("post_rst");

    // Reset in the middle of a CP0 window
    id_cp0_op = 1'b1; step("cp0_issue");
    id_cp0_op = 1'b0; step("cp0_win1");
    Reset = 1'b1; #1; chk("rst_mid_outs", 32'(got_vec()), 32'd0);
    step("rst_mid_a");
    step("rst_mid_b");
    Reset = 1'b0; #1; chk("rst_clear_outs", 32'(got_vec()), 32'd0);
    for (int i = 0; i < 4; i++) step("post_rst_idle");

    // Load-use hazard and the $zero exception
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1; chk("haz_direct", 32'({hazard, idex_nop}), 32'b11);
    step("haz_r8");
    ex_rt = 5'd0; id_rs = 5'd0;
    #1; chk("haz_zero", 32'(hazard), 32'd0);
    step("haz_r0");
    idle_inputs(); step("idle");

    // Branch pulse: window on the next BR_B cycles
    id_branch = 1'b1; step("br_issue");
    id_branch = 1'b0;
    br_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      #1; br_cycles += int'(BranchBubble && ifid_nop);
      step("br_win");
    end
    chk("br_len", 32'(br_cycles), 32'(BR_B));

    // Branch and CP0 together: CP0 wins
    id_branch = 1'b1; id_cp0_op = 1'b1; step("both_issue");
    idle_inputs();
    br_cycles = 0; cp0_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      #1; br_cycles += int'(BranchBubble); cp0_cycles += int'(cp0Bubble);
      step("both_win");
    end
    chk("both_cp0_len", 32'(cp0_cycles), 32'(CP0_B));
    chk("both_no_br", 32'(br_cycles), 32'd0);

    // Hazard coincident with a branch delays the window by one cycle
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1; id_branch = 1'b1;
    #1; chk("hzbr_haz", 32'({hazard, BranchBubble}), 32'b10);
    step("hzbr_c0");
    ex_mem_read = 1'b0;
    #1; chk("hzbr_retry", 32'({hazard, BranchBubble}), 32'b00);
    step("hzbr_c1");
    idle_inputs();
    #1; chk("hzbr_bb1", 32'(BranchBubble), 32'd1);
    step("hzbr_c2");
    #1; chk("hzbr_bb2", 32'(BranchBubble), 32'd1);
    step("hzbr_c3");
    #1; chk("hzbr_done", 32'(BranchBubble), 32'd0);
    step("hzbr_c4");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      Reset       = ($urandom_range(0, 49) == 0);
      id_rs       = REG_W'($urandom_range(0, 3));
      id_rt       = REG_W'($urandom_range(0, 3));
      ex_rt       = REG_W'($urandom_range(0, 3));
      id_use_rs   = 1'($urandom);
      id_use_rt   = 1'($urandom);
      ex_mem_read = 1'($urandom);
      id_branch   = ($urandom_range(0, 5) == 0);
      id_cp0_op   = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    Reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 8; i++) step("drain");

`ifdef STALL_CTRL_PERF_EN
    Reset = 1'b1; step("perf_rst");
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      id_branch = 1'b1; step("perf_br_issue");
      id_branch = 1'b0;
      for (int i = 0; i < 3; i++) step("perf_br_win");
    end
    chk("perf_br", perf_br, 32'd6);
    chk("perf_haz", perf_haz, 32'd0);
    chk("perf_cp0", perf_cp0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
